// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command/response port plus APB requester bus of the bridge
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, paddr, pwrite, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns valid/ready commands into APB SETUP/ACCESS transfers with timeout
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input logic pclk,
  input logic presetn,
  apb_master_bridge_if.master bus
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  assign bus.cmd_ready = state == IDLE;
  // transfer sequencer: every APB and response output is registered here
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.paddr       <= '0;
      bus.pwrite      <= 1'b0;
      bus.pwdata      <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          bus.paddr   <= bus.cmd_addr;
          bus.pwrite  <= bus.cmd_write;
          bus.pwdata  <= bus.cmd_wdata;
          bus.psel    <= 1'b1;
          bus.penable <= 1'b0;
          state       <= SETUP;
        end
        SETUP: begin
          bus.penable <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: if (bus.pready) begin
          bus.psel        <= 1'b0;
          bus.penable     <= 1'b0;
          bus.rsp_valid   <= 1'b1;
          bus.rsp_rdata   <= bus.pwrite ? '0 : bus.prdata;
          bus.rsp_err     <= bus.pslverr;
          bus.rsp_timeout <= 1'b0;
          state           <= IDLE;
        end else if (TIMEOUT != 0 && cnt == LAST) begin
          bus.psel        <= 1'b0;
          bus.penable     <= 1'b0;
          bus.rsp_valid   <= 1'b1;
          bus.rsp_rdata   <= '0;
          bus.rsp_err     <= 1'b1;
          bus.rsp_timeout <= 1'b1;
          state           <= IDLE;
        end else
          cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of the APB bridge handshake, waits, errors, timeout and reset
module tb_apb_master_bridge;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int n = 0;
  apb_master_bridge_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();
  apb_master_bridge #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
    .pclk(pclk),
    .presetn(presetn),
    .bus(bus)
  );
  // free-running 10 ns clock
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge pclk);
    #1;
  endtask
  task automatic cmd(input logic w, input logic [3:0] a, input logic [7:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask
  // directed stimulus with hand-computed expectations
  initial begin
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.prdata = 0; bus.pready = 0; bus.pslverr = 0;
    #1;
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    step(); step();
    presetn = 1'b1;
    step();
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    // zero-wait write
    bus.pready = 1;
    cmd(1, 4'd2, 8'hAA);
    step();
    bus.cmd_valid = 0;
    chk("w_setup_psel", bus.psel, 1);
    chk("w_setup_penable", bus.penable, 0);
    chk("w_setup_paddr", bus.paddr, 2);
    chk("w_setup_pwdata", bus.pwdata, 8'hAA);
    chk("w_setup_pwrite", bus.pwrite, 1);
    chk("w_setup_cmd_ready", bus.cmd_ready, 0);
    step();
    chk("w_access_psel", bus.psel, 1);
    chk("w_access_penable", bus.penable, 1);
    chk("w_access_paddr", bus.paddr, 2);
    step();
    chk("w_rsp_valid", bus.rsp_valid, 1);
    chk("w_rsp_err", bus.rsp_err, 0);
    chk("w_rsp_rdata", bus.rsp_rdata, 0);
    chk("w_psel_off", bus.psel, 0);
    chk("w_cmd_ready", bus.cmd_ready, 1);
    step();
    chk("w_rsp_pulse", bus.rsp_valid, 0);
    chk("w_paddr_hold", bus.paddr, 2);
    // read with two wait states; pslverr while pready low must be ignored
    bus.pready = 0;
    bus.pslverr = 1;
    cmd(0, 4'd3, 8'h00);
    step();
    bus.cmd_valid = 0;
    step();
    chk("rd_acc1_penable", bus.penable, 1);
    step();
    chk("rd_acc2_penable", bus.penable, 1);
    chk("rd_acc2_paddr", bus.paddr, 3);
    chk("rd_acc2_rsp_valid", bus.rsp_valid, 0);
    step();
    chk("rd_acc3_penable", bus.penable, 1);
    chk("rd_acc3_paddr", bus.paddr, 3);
    bus.pready = 1;
    bus.pslverr = 0;
    bus.prdata = 8'h34;
    step();
    chk("rd_rsp_valid", bus.rsp_valid, 1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 8'h34);
    chk("rd_rsp_err", bus.rsp_err, 0);
    chk("rd_psel_off", bus.psel, 0);
    step();
    chk("rd_rdata_hold", bus.rsp_rdata, 8'h34);
    // completer error on a write
    bus.pslverr = 1;
    cmd(1, 4'd1, 8'hFF);
    step();
    bus.cmd_valid = 0;
    step(); step();
    chk("err_rsp_valid", bus.rsp_valid, 1);
    chk("err_rsp_err", bus.rsp_err, 1);
    chk("err_rsp_timeout", bus.rsp_timeout, 0);
    chk("err_rsp_rdata", bus.rsp_rdata, 0);
    bus.pslverr = 0;
    step();
    // timeout: pready stuck low for 16 ACCESS cycles
    bus.pready = 0;
    bus.prdata = 8'h55;
    cmd(0, 4'd5, 8'h00);
    step();
    bus.cmd_valid = 0;
    step();
    n = 0;
    while (bus.penable && n < 40) begin
      n++;
      step();
    end
    chk("to_access_cycles", n, 16);
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_rsp_err", bus.rsp_err, 1);
    chk("to_rsp_timeout", bus.rsp_timeout, 1);
    chk("to_rsp_rdata", bus.rsp_rdata, 0);
    chk("to_psel", bus.psel, 0);
    step();
    chk("to_cmd_ready", bus.cmd_ready, 1);
    chk("to_rsp_pulse", bus.rsp_valid, 0);
    chk("to_timeout_hold", bus.rsp_timeout, 1);
    // pready arriving on the final timeout edge completes normally
    bus.prdata = 8'h77;
    cmd(0, 4'd6, 8'h00);
    step();
    bus.cmd_valid = 0;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("edge_still_access", bus.penable, 1);
    bus.pready = 1;
    step();
    chk("edge_rsp_valid", bus.rsp_valid, 1);
    chk("edge_rsp_timeout", bus.rsp_timeout, 0);
    chk("edge_rsp_err", bus.rsp_err, 0);
    chk("edge_rsp_rdata", bus.rsp_rdata, 8'h77);
    step();
    // back-to-back with cmd_valid held high; read returns the completer value
    bus.prdata = 8'h5A;
    cmd(1, 4'd0, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("b2b_setup_psel", bus.psel, 1);
      chk("b2b_setup_penable", bus.penable, 0);
      chk("b2b_setup_paddr", bus.paddr, k == 0 ? 0 : (k == 3 ? 3 : 1));
      chk("b2b_setup_pwrite", bus.pwrite, k == 3 ? 0 : 1);
      if (k < 3) chk("b2b_setup_pwdata", bus.pwdata, k == 2 ? 8'h00 : 8'hFF);
      if (k == 3) bus.cmd_valid = 0;
      step();
      chk("b2b_access_penable", bus.penable, 1);
      step();
      chk("b2b_rsp_valid", bus.rsp_valid, 1);
      chk("b2b_psel_gap", bus.psel, 0);
      chk("b2b_cmd_ready", bus.cmd_ready, 1);
      chk("b2b_rsp_rdata", bus.rsp_rdata, k == 3 ? 8'h5A : 8'h00);
      if (k == 0) cmd(1, 4'd1, 8'hFF);
      if (k == 1) cmd(1, 4'd1, 8'h00);
      if (k == 2) cmd(0, 4'd3, 8'h00);
    end
    step();
    chk("b2b_idle_psel", bus.psel, 0);
    chk("b2b_idle_rsp_valid", bus.rsp_valid, 0);
    // asynchronous reset in the middle of ACCESS
    bus.pready = 0;
    cmd(1, 4'd7, 8'h11);
    step();
    bus.cmd_valid = 0;
    step();
    chk("rst_mid_penable_before", bus.penable, 1);
    #2 presetn = 1'b0;
    #1;
    chk("rst_mid_psel", bus.psel, 0);
    chk("rst_mid_penable", bus.penable, 0);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mid_paddr", bus.paddr, 0);
    #2 presetn = 1'b1;
    bus.pready = 1;
    step();
    chk("rst_after_cmd_ready", bus.cmd_ready, 1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n += int'(bus.rsp_valid) + int'(bus.psel);
      step();
    end
    chk("rst_no_stale", n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester: turns a simple valid/ready command port into APB SETUP/ACCESS transfers.
- Drives psel/penable/paddr/pwrite/pwdata toward one APB completer, such as the GPIO core.
- Returns read data, error and timeout status on a one-cycle response strobe.
- Sits between a control engine or CPU-side sequencer and the peripheral bus.

Parameters:
ADDR_WIDTH, 4, width of paddr/cmd_addr
DATA_WIDTH, 8, width of pwdata/prdata/cmd_wdata/rsp_rdata
TIMEOUT, 16, max ACCESS cycles waiting for pready; 0 disables timeout (wait forever)

Ports:
pclk  in  1  clock, all logic on rising edge
presetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target register address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle completion strobe, no backpressure
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/timeouts)
rsp_err  out  1  pslverr seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_WIDTH  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  APB read data
pready  in  1  completer ready
pslverr  in  1  completer error, valid with pready in ACCESS

Behaviour:
- Reset (presetn low, async): state=IDLE; every output except cmd_ready = 0 (psel, penable, paddr, pwrite, pwdata, rsp_*); wait counter = 0. cmd_ready = 1 once state is IDLE.
- Reset mid-transfer: psel/penable drop immediately (async); the transfer is abandoned; no rsp_valid is issued.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs and rsp_* are registered.
- cmd_ready = (state==IDLE), combinational from state.
- IDLE: on cmd_valid & cmd_ready:
  - latch paddr<=cmd_addr, pwrite<=cmd_write, pwdata<=cmd_wdata;
  - psel<=1, penable<=0; -> SETUP.
- SETUP (exactly 1 cycle): penable<=1, clear wait counter; -> ACCESS.
- ACCESS, pready=1 at edge (transfer completes):
  - psel<=0, penable<=0;
  - rsp_valid<=1;
  - rsp_rdata<=pwrite ? 0 : prdata;
  - rsp_err<=pslverr, rsp_timeout<=0;
  - -> IDLE.
- ACCESS, pready=0: hold all APB outputs; increment wait counter.
  - If TIMEOUT!=0 and counter reaches TIMEOUT-1 with pready still low: psel<=0, penable<=0, rsp_valid<=1, rsp_err<=1, rsp_timeout<=1, rsp_rdata<=0; -> IDLE.
  - pready and timeout on the same edge: pready wins (normal completion).
- paddr/pwrite/pwdata stay stable from SETUP through ACCESS and hold their last value in IDLE (no X or change until the next accept).
- rsp_valid is high for exactly 1 cycle. rsp_rdata/rsp_err/rsp_timeout hold until the next completion.
- Latency with command accepted at edge N and zero-wait completer:
  - SETUP visible after N;
  - ACCESS after N+1;
  - completion at N+2, rsp_valid high during cycle N+2..N+3.
- Throughput: cmd_ready rises in the same cycle rsp_valid is high, so back-to-back commands cost 3 cycles each with a zero-wait completer. psel deasserts for at least 1 cycle between transfers.
- cmd_* is ignored outside IDLE.
- pslverr is ignored when pready=0.

Test Plan:
- Zero-wait write: cmd addr=2, wdata=0xAA, write=1, pready tied 1 -> psel=1/penable=0 for 1 cycle, then psel=1/penable=1 with paddr=2, pwdata=0xAA for 1 cycle; rsp_valid pulse with rsp_err=0, rsp_rdata=0x00; total 3 cycles from accept to rsp_valid.
- Wait-state read: addr=3, completer holds pready=0 for 2 ACCESS cycles then pready=1 with prdata=0x34 -> ACCESS lasts 3 cycles, paddr stable at 3, rsp_rdata=0x34, rsp_err=0.
- Slave error: write addr=1, wdata=0xFF, pready=1 with pslverr=1 -> rsp_valid=1, rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=16, pready stuck 0 -> exactly 16 ACCESS cycles, then psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0; cmd_ready=1 the next cycle.
- Back-to-back: cmd_valid held high with 4 commands (dir addr0=0xFF, mode addr1=0xFF, mode addr1=0x00, read addr3), zero-wait completer -> 4 rsp_valid pulses spaced 3 cycles apart, psel low for 1 cycle between transfers, read returns the gpio_in value.
- Reset mid-ACCESS: assert presetn=0 while penable=1 -> psel, penable, rsp_valid=0 immediately without waiting for a clock; after release cmd_ready=1 and no stale response is issued.
